// File: rtl/fiat_25519_carry_square_mul_pipe.sv
// Pipelined unsigned multiplier: limb-split partial products, summed, then optional delay stages.
// Optional sideband tag path enabled by defining FIAT_MUL_TAG_EN.
module fiat_25519_carry_square_mul_pipe #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 33,
  parameter int din1_WIDTH = 32,
  parameter int dout_WIDTH = 64,
  parameter int SPLIT_W    = 17,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout
`ifdef FIAT_MUL_TAG_EN
  ,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic [TAG_WIDTH-1:0]  out_tag
`endif
);

  localparam int HiW   = din0_WIDTH - SPLIT_W;
  localparam int LoPW  = SPLIT_W + din1_WIDTH;
  localparam int HiPW  = HiW + din1_WIDTH;
  localparam int ProdW = din0_WIDTH + din1_WIDTH;
  localparam int SumW  = (ProdW > dout_WIDTH) ? ProdW : dout_WIDTH;

  logic [NUM_STAGE:1]    v_q;
  logic [NUM_STAGE:1]    load;
  logic                  tail_full;

  logic [LoPW-1:0]       pp_lo_d, pp_lo_q;
  logic [HiPW-1:0]       pp_hi_d, pp_hi_q;
  logic [SumW-1:0]       sum_full;
  logic [dout_WIDTH-1:0] sum_d;
  logic [dout_WIDTH-1:0] data_q [2:NUM_STAGE];

  // A stage may load when it is empty or any stage downstream of it is empty,
  // or when the consumer takes the head result this cycle.
  always_comb begin
    load      = '0;
    tail_full = 1'b1;
    for (int k = 1; k <= NUM_STAGE; k++) begin
      tail_full = 1'b1;
      for (int j = k; j <= NUM_STAGE; j++) begin
        tail_full = tail_full & v_q[j];
      end
      load[k] = !tail_full || out_ready;
    end
  end

  always_comb begin
    pp_lo_d  = LoPW'(din0[SPLIT_W-1:0]) * LoPW'(din1);
    pp_hi_d  = HiPW'(din0[din0_WIDTH-1:SPLIT_W]) * HiPW'(din1);
    sum_full = SumW'(pp_lo_q) + (SumW'(pp_hi_q) << SPLIT_W);
    sum_d    = sum_full[dout_WIDTH-1:0];
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      v_q     <= '0;
      pp_lo_q <= '0;
      pp_hi_q <= '0;
      for (int k = 2; k <= NUM_STAGE; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      if (load[1]) begin
        v_q[1] <= in_valid;
        if (in_valid) begin
          pp_lo_q <= pp_lo_d;
          pp_hi_q <= pp_hi_d;
        end
      end
      if (load[2]) begin
        v_q[2] <= v_q[1];
        if (v_q[1]) data_q[2] <= sum_d;
      end
      for (int k = 3; k <= NUM_STAGE; k++) begin
        if (load[k]) begin
          v_q[k] <= v_q[k-1];
          if (v_q[k-1]) data_q[k] <= data_q[k-1];
        end
      end
    end
  end

`ifdef FIAT_MUL_TAG_EN
  logic [TAG_WIDTH-1:0] tag_q [1:NUM_STAGE];

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int k = 1; k <= NUM_STAGE; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      if (load[1] && in_valid) tag_q[1] <= in_tag;
      for (int k = 2; k <= NUM_STAGE; k++) begin
        if (load[k] && v_q[k-1]) tag_q[k] <= tag_q[k-1];
      end
    end
  end

  assign out_tag = tag_q[NUM_STAGE];
`endif

  assign in_ready  = load[1];
  assign out_valid = v_q[NUM_STAGE];
  assign dout      = data_q[NUM_STAGE];

endmodule

// File: tb/tb_fiat_25519_carry_square_mul_pipe.sv
// Self-checking bench: randomized operands against a plain (a*b) mod 2^64 reference,
// with three pipeline/split configurations sharing one stimulus source.
module tb_fiat_25519_carry_square_mul_pipe;

  localparam int S  = 3;
  localparam int S2 = 2;
  localparam int S8 = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready;
  logic [32:0] din0;
  logic [31:0] din1;
  logic        in_ready, out_valid, in_ready_s2, out_valid_s2, in_ready_s8, out_valid_s8;
  logic [63:0] dout, dout_s2, dout_s8;
`ifdef FIAT_MUL_TAG_EN
  logic [7:0]  in_tag, out_tag, out_tag_s2, out_tag_s8;
  logic [7:0]  exp_tag_q[$], got_tag_q[$];
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] exp_q[$], got_q[$];

  always #5 clk = ~clk;

  fiat_25519_carry_square_mul_pipe #(
    .ID(1), .NUM_STAGE(S), .din0_WIDTH(33), .din1_WIDTH(32), .dout_WIDTH(64), .SPLIT_W(17),
    .TAG_WIDTH(8)
  ) u_dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .din0(din0),
    .din1(din1), .out_valid(out_valid), .out_ready(out_ready), .dout(dout)
`ifdef FIAT_MUL_TAG_EN
    , .in_tag(in_tag), .out_tag(out_tag)
`endif
  );

  fiat_25519_carry_square_mul_pipe #(
    .ID(2), .NUM_STAGE(S2), .din0_WIDTH(33), .din1_WIDTH(32), .dout_WIDTH(64), .SPLIT_W(1),
    .TAG_WIDTH(8)
  ) u_dut_s2 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s2), .din0(din0),
    .din1(din1), .out_valid(out_valid_s2), .out_ready(out_ready), .dout(dout_s2)
`ifdef FIAT_MUL_TAG_EN
    , .in_tag(in_tag), .out_tag(out_tag_s2)
`endif
  );

  fiat_25519_carry_square_mul_pipe #(
    .ID(3), .NUM_STAGE(S8), .din0_WIDTH(33), .din1_WIDTH(32), .dout_WIDTH(64), .SPLIT_W(32),
    .TAG_WIDTH(8)
  ) u_dut_s8 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s8), .din0(din0),
    .din1(din1), .out_valid(out_valid_s8), .out_ready(out_ready), .dout(dout_s8)
`ifdef FIAT_MUL_TAG_EN
    , .in_tag(in_tag), .out_tag(out_tag_s8)
`endif
  );

  function automatic logic [63:0] golden(input logic [32:0] a, input logic [31:0] b);
    logic [127:0] p;
    p = 128'(a) * 128'(b);
    return p[63:0];
  endfunction

  function automatic logic [32:0] rand33();
    return {1'($urandom), 32'($urandom)};
  endfunction

  // Monitor one cycle of the main instance: log handshakes mid-cycle, then step past the edge.
  task automatic tick();
    @(negedge clk);
    if (out_valid && out_ready) got_q.push_back(dout);
    if (in_valid && in_ready) exp_q.push_back(golden(din0, din1));
`ifdef FIAT_MUL_TAG_EN
    if (out_valid && out_ready) got_tag_q.push_back(out_tag);
    if (in_valid && in_ready) exp_tag_q.push_back(in_tag);
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int limit);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < limit && got_q.size() < exp_q.size(); c++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din0 = '0; din1 = '0;
`ifdef FIAT_MUL_TAG_EN
    in_tag = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    vectors++;
    if (dout !== 64'd0) begin
      miscompares++; $display("FAIL reset_dout: got %h want 0", dout);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_full_scale();
    out_ready = 1'b1; in_valid = 1'b1;
    din0 = 33'h1_FFFF_FFFF; din1 = 32'hFFFF_FFFF;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL full_in_ready: got %b want 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int e = 0; e < S; e++) begin
      vectors++;
      if (out_valid !== (e == S - 1)) begin
        miscompares++;
        $display("FAIL full_latency: edge+%0d out_valid got %b want %b", e, out_valid, e == S - 1);
      end
      if (e < S - 1) begin
        @(posedge clk);
        #1;
      end
    end
    vectors++;
    if (dout !== 64'hFFFF_FFFD_0000_0001) begin
      miscompares++; $display("FAIL full_value: got %h want fffffffd00000001", dout);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL full_consumed: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int drops;
    int n_ticks;
    logic [63:0] g;
    exp_q.delete(); got_q.delete();
    drops = 0; n_ticks = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; din0 = rand33(); din1 = $urandom;
      if (in_ready !== 1'b1) drops++;
      tick();
      n_ticks++;
    end
    in_valid = 1'b0;
    while (got_q.size() < 100 && n_ticks < 200) begin
      tick();
      n_ticks++;
    end
    vectors++;
    if (drops !== 0) begin
      miscompares++; $display("FAIL b2b_in_ready: %0d low cycles, want 0", drops);
    end
    vectors++;
    if (n_ticks !== 100 + S) begin
      miscompares++; $display("FAIL b2b_throughput: got %0d cycles want %0d", n_ticks, 100 + S);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      vectors++;
      if (g !== exp_q[i]) begin
        miscompares++; $display("FAIL b2b_result[%0d]: got %h want %h", i, g, exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] held;
    logic [63:0] g;
    exp_q.delete(); got_q.delete();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 20 && in_ready; c++) begin
      din0 = rand33(); din1 = $urandom;
      tick();
    end
    vectors++;
    if (exp_q.size() !== S) begin
      miscompares++; $display("FAIL bp_accepted: got %0d want %0d", exp_q.size(), S);
    end
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++; $display("FAIL bp_in_ready: got %b want 0", in_ready);
    end
    held = dout;
    for (int c = 0; c < 5; c++) begin
      din0 = rand33(); din1 = $urandom;
      tick();
      vectors++;
      if (out_valid !== 1'b1 || dout !== held) begin
        miscompares++;
        $display("FAIL bp_stable: valid %b dout %h want 1 %h", out_valid, dout, held);
      end
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL bp_simul_ready: got %b want 1", in_ready);
    end
    for (int c = 0; c < 4; c++) begin
      din0 = rand33(); din1 = $urandom;
      tick();
    end
    drain(40);
    vectors++;
    if (exp_q.size() !== S + 4 || got_q.size() !== S + 4) begin
      miscompares++;
      $display("FAIL bp_counts: in %0d out %0d want %0d", exp_q.size(), got_q.size(), S + 4);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      vectors++;
      if (g !== exp_q[i]) begin
        miscompares++; $display("FAIL bp_order[%0d]: got %h want %h", i, g, exp_q[i]);
      end
    end
  endtask

  task automatic test_random_ready();
    logic [63:0] g;
    exp_q.delete(); got_q.delete();
    for (int c = 0; c < 200; c++) begin
      in_valid = 1'($urandom); out_ready = ($urandom_range(0, 3) != 0);
      din0 = rand33(); din1 = $urandom;
      tick();
    end
    drain(40);
    vectors++;
    if (got_q.size() !== exp_q.size()) begin
      miscompares++; $display("FAIL rr_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      vectors++;
      if (g !== exp_q[i]) begin
        miscompares++; $display("FAIL rr_result[%0d]: got %h want %h", i, g, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_midflight();
    exp_q.delete(); got_q.delete();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; din0 = rand33() | 33'd1; din1 = $urandom | 32'd1;
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || dout !== 64'd0) begin
      miscompares++; $display("FAIL mid_reset: valid %b dout %h want 0 0", out_valid, dout);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL mid_in_ready: got %b want 1", in_ready);
    end
    exp_q.delete(); got_q.delete();
    repeat (10) tick();
    vectors++;
    if (got_q.size() !== 0) begin
      miscompares++; $display("FAIL mid_stale: got %0d results want 0", got_q.size());
    end
  endtask

  task automatic test_boundary();
    logic [32:0] a_tab [5];
    logic [31:0] b_tab [5];
    logic [63:0] g;
    a_tab = '{33'd0, 33'h2_0000, 33'h1_FFFF, 33'h1_0000_0000, 33'h1_FFFF_FFFF};
    b_tab = '{32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1};
    exp_q.delete(); got_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; din0 = a_tab[i]; din1 = b_tab[i];
      tick();
    end
    drain(20);
    g = (got_q.size() > 0) ? got_q[0] : 'x;
    vectors++;
    if (g !== 64'd0) begin
      miscompares++; $display("FAIL bnd_zero: got %h want 0", g);
    end
    g = (got_q.size() > 1) ? got_q[1] : 'x;
    vectors++;
    if (g !== 64'h6_0000) begin
      miscompares++; $display("FAIL bnd_limb_edge: got %h want 60000", g);
    end
    for (int i = 2; i < 5; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      vectors++;
      if (g !== exp_q[i]) begin
        miscompares++; $display("FAIL bnd_case[%0d]: got %h want %h", i, g, exp_q[i]);
      end
    end
  endtask

  task automatic test_sweep();
    logic [63:0] e2[$], g2[$], e8[$], g8[$];
    logic [63:0] g;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    for (int c = 0; c < 92; c++) begin
      in_valid = (c < 80) ? 1'($urandom) : 1'b0;
      din0 = (c == 0) ? 33'd2 : (c == 1) ? 33'h1_0000_0000 : rand33();
      din1 = $urandom;
      if (c < 2) in_valid = 1'b1;
      @(negedge clk);
      if (in_valid && in_ready_s2) e2.push_back(golden(din0, din1));
      if (in_valid && in_ready_s8) e8.push_back(golden(din0, din1));
      if (out_valid_s2) g2.push_back(dout_s2);
      if (out_valid_s8) g8.push_back(dout_s8);
      @(posedge clk);
      #1;
    end
    vectors++;
    if (g2.size() !== e2.size() || g8.size() !== e8.size()) begin
      miscompares++;
      $display("FAIL sweep_counts: s2 %0d/%0d s8 %0d/%0d", g2.size(), e2.size(), g8.size(),
               e8.size());
    end
    for (int i = 0; i < e2.size(); i++) begin
      g = (i < g2.size()) ? g2[i] : 'x;
      vectors++;
      if (g !== e2[i]) begin
        miscompares++; $display("FAIL sweep_s2[%0d]: got %h want %h", i, g, e2[i]);
      end
    end
    for (int i = 0; i < e8.size(); i++) begin
      g = (i < g8.size()) ? g8[i] : 'x;
      vectors++;
      if (g !== e8[i]) begin
        miscompares++; $display("FAIL sweep_s8[%0d]: got %h want %h", i, g, e8[i]);
      end
    end
  endtask

`ifdef FIAT_MUL_TAG_EN
  task automatic test_tag();
    logic [7:0] t;
    int idx;
    exp_q.delete(); got_q.delete(); exp_tag_q.delete(); got_tag_q.delete();
    idx = 1;
    for (int c = 0; c < 200 && idx <= 16; c++) begin
      in_valid = 1'b1; in_tag = 8'(idx); out_ready = 1'($urandom);
      din0 = rand33(); din1 = $urandom;
      tick();
      if (exp_tag_q.size() == idx) idx++;
    end
    drain(40);
    vectors++;
    if (got_tag_q.size() !== 16) begin
      miscompares++; $display("FAIL tag_count: got %0d want 16", got_tag_q.size());
    end
    for (int i = 0; i < 16; i++) begin
      t = (i < got_tag_q.size()) ? got_tag_q[i] : 'x;
      vectors++;
      if (t !== 8'(i + 1)) begin
        miscompares++; $display("FAIL tag[%0d]: got %h want %h", i, t, 8'(i + 1));
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_full_scale();
    test_back_to_back();
    test_backpressure();
    test_random_ready();
    test_reset_midflight();
    test_boundary();
`ifdef FIAT_MUL_TAG_EN
    test_tag();
`endif
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
